// File: rtl/bram_fifo.sv
// bram_fifo: single-clock first-word-fall-through FIFO on one 4 kbit block RAM.
// Geometry pairs: 256x16, 512x8, 1024x4, 2048x2 (DATA_WIDTH / ADDR_WIDTH).
// A 2-entry prefetch buffer hides the 1-cycle RAM read latency, so one push
// and one pop per cycle are sustained.
// Optional feature: define BRAM_FIFO_LEVEL_EN to add level_o, almost_full_o
// and almost_empty_o (all registered, tracking the post-edge occupancy).

// Behavioural equivalent of the SB_RAM40_4K block: same port names and mode
// encoding (mode m -> 16>>m bits x 256<<m words). Each data bit sits on the
// lane used by the vendor wrappers: width 8 on even bits, width 4 on bit
// 4i+1, width 2 on bit 8i+3. MASK only applies in 16-bit mode.
module bram_fifo_ram40 #(
   parameter int READ_MODE  = 0,
   parameter int WRITE_MODE = 0
) (
   output logic [15:0] RDATA,
   input  logic        RCLK,
   input  logic        RCLKE,
   input  logic        RE,
   input  logic [10:0] RADDR,
   input  logic        WCLK,
   input  logic        WCLKE,
   input  logic        WE,
   input  logic [10:0] WADDR,
   input  logic [15:0] MASK,
   input  logic [15:0] WDATA
);
   localparam int DW       = 16 >> READ_MODE;
   localparam int AW       = 8 + READ_MODE;
   localparam int STRIDE   = 16 / DW;
   localparam int LANE_OFS = (READ_MODE == 2) ? 1 : (READ_MODE == 3) ? 3 : 0;

   logic [DW-1:0] mem [0:(1 << AW)-1];
   logic [DW-1:0] wword;
   logic [DW-1:0] wbit_en;
   logic [DW-1:0] rword_q;
   logic          unused_ram_bits;

   if (READ_MODE != WRITE_MODE) begin : g_bad_mode
      $error("bram_fifo_ram40: READ_MODE and WRITE_MODE must match");
   end

   // Gather the write word from its RAM lanes; build per-bit write enables.
   always_comb begin
      wword   = '0;
      wbit_en = '1;
      for (int i = 0; i < DW; i++) begin
         wword[i] = WDATA[i*STRIDE + LANE_OFS];
         if (WRITE_MODE == 0) wbit_en[i] = ~MASK[i];
      end
   end

   // Write port.
   always_ff @(posedge WCLK) begin
      if (WCLKE && WE) begin
         for (int i = 0; i < DW; i++) begin
            if (wbit_en[i]) mem[WADDR[AW-1:0]][i] <= wword[i];
         end
      end
   end

   // Registered read port (1-cycle latency).
   always_ff @(posedge RCLK) begin
      if (RCLKE && RE) rword_q <= mem[RADDR[AW-1:0]];
   end

   // Scatter the read word back onto its lanes; other lanes read as zero.
   always_comb begin
      RDATA = '0;
      for (int i = 0; i < DW; i++) begin
         RDATA[i*STRIDE + LANE_OFS] = rword_q[i];
      end
   end

   assign unused_ram_bits = ^{RADDR, WADDR, MASK, WDATA};
endmodule

module bram_fifo #(
   parameter int DATA_WIDTH          = 16,
   parameter int ADDR_WIDTH          = 8,
   parameter int ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - 4,
   parameter int ALMOST_EMPTY_THRESH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o
`ifdef BRAM_FIFO_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
`endif
);
   localparam int PW       = ADDR_WIDTH + 1;
   localparam int DEPTH    = 1 << ADDR_WIDTH;
   localparam int MODE     = (DATA_WIDTH == 16) ? 0 : (DATA_WIDTH == 8) ? 1 :
                             (DATA_WIDTH == 4)  ? 2 : 3;
   localparam int STRIDE   = 16 / DATA_WIDTH;
   localparam int LANE_OFS = (DATA_WIDTH == 4) ? 1 : (DATA_WIDTH == 2) ? 3 : 0;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   if (!((DATA_WIDTH == 16 && ADDR_WIDTH == 8)  ||
         (DATA_WIDTH == 8  && ADDR_WIDTH == 9)  ||
         (DATA_WIDTH == 4  && ADDR_WIDTH == 10) ||
         (DATA_WIDTH == 2  && ADDR_WIDTH == 11))) begin : g_bad_geometry
      $error("bram_fifo: illegal DATA_WIDTH/ADDR_WIDTH pairing");
   end

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q, count_d;
   logic                  s_ready_q, s_ready_d;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [DATA_WIDTH-1:0] buf_d [2];
   logic [1:0]            buf_cnt_q, buf_cnt_d;
   logic                  inflight_q, inflight_d;

   logic                  push, pop, rd_issue, ram_nonempty;
   logic [1:0]            committed;
   logic [1:0]            slot;
   logic [15:0]           ram_wdata, ram_rdata;
   logic [DATA_WIDTH-1:0] ram_rword;
   logic                  unused_rdata;

   assign push         = s_valid_i && s_ready_q;
   assign pop          = (buf_cnt_q != 2'd0) && m_ready_i;
   assign ram_nonempty = (wr_ptr_q != rd_ptr_q);
   // Entries already owed to the buffer after this cycle's pop; a new read
   // may only be issued while that leaves room for its data.
   assign committed    = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   assign rd_issue     = ram_nonempty && (committed < 2'd2);
   assign slot         = buf_cnt_q - {1'b0, pop};

   assign s_ready_o = s_ready_q;
   assign m_valid_o = (buf_cnt_q != 2'd0);
   assign m_data_o  = buf_q[0];

   // Place write data onto the RAM lanes for this geometry.
   always_comb begin
      ram_wdata = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ram_wdata[i*STRIDE + LANE_OFS] = s_data_i[i];
      end
   end

   // Pull read data back off the RAM lanes.
   always_comb begin
      ram_rword = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ram_rword[i] = ram_rdata[i*STRIDE + LANE_OFS];
      end
   end

   assign unused_rdata = ^ram_rdata;

   bram_fifo_ram40 #(
      .READ_MODE  (MODE),
      .WRITE_MODE (MODE)
   ) u_ram (
      .RDATA (ram_rdata),
      .RCLK  (clk_i),
      .RCLKE (1'b1),
      .RE    (rd_issue),
      .RADDR (11'(rd_ptr_q[ADDR_WIDTH-1:0])),
      .WCLK  (clk_i),
      .WCLKE (1'b1),
      .WE    (push),
      .WADDR (11'(wr_ptr_q[ADDR_WIDTH-1:0])),
      .MASK  (16'h0000),
      .WDATA (ram_wdata)
   );

   // Pointer, occupancy and input-ready next state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = rd_issue;
      if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_issue) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      s_ready_d = (count_d < DEPTH_P);
   end

   // Prefetch buffer: shift on pop, land returning read data behind the
   // surviving entries. Entry 0 keeps its last value when the buffer drains.
   always_comb begin
      buf_d[0]  = buf_q[0];
      buf_d[1]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
      if (pop && buf_cnt_q == 2'd2) buf_d[0] = buf_q[1];
      if (inflight_q) begin
         if (slot == 2'd0) buf_d[0] = ram_rword;
         else              buf_d[1] = ram_rword;
      end
   end

   // State registers; reset drops stored words and any read in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         s_ready_q  <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         buf_cnt_q  <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         s_ready_q  <= s_ready_d;
         buf_q[0]   <= buf_d[0];
         buf_q[1]   <= buf_d[1];
         buf_cnt_q  <= buf_cnt_d;
         inflight_q <= inflight_d;
      end
   end

`ifdef BRAM_FIFO_LEVEL_EN
   logic [ADDR_WIDTH:0] level_q;
   logic                almost_full_q;
   logic                almost_empty_q;

   // Level flags follow the occupancy after this edge's push/pop.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         level_q        <= '0;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         level_q        <= count_d;
         almost_full_q  <= (int'(count_d) >= ALMOST_FULL_THRESH);
         almost_empty_q <= (int'(count_d) <= ALMOST_EMPTY_THRESH);
      end
   end

   assign level_o        = level_q;
   assign almost_full_o  = almost_full_q;
   assign almost_empty_o = almost_empty_q;
`endif
endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Parametrised single-clock FIFO built on one SB_RAM40_4K block.
- Width and depth are selected together (256x16, 512x8, 1024x4, 2048x2), with valid/ready handshakes on both sides and a first-word-fall-through output stage.
- Successor to the fixed-geometry dram_* wrappers; used as the standard buffering primitive between pipeline stages.

Parameters:
- DATA_WIDTH, 16, word width; legal values 16, 8, 4, 2.
- ADDR_WIDTH, 8, log2 of depth; must equal 8 for width 16, 9 for 8, 10 for 4, 11 for 2. Any other pairing is an elaboration error.
- ALMOST_FULL_THRESH, 2^ADDR_WIDTH-4, level at or above which almost_full asserts (optional feature only).
- ALMOST_EMPTY_THRESH, 4, level at or below which almost_empty asserts (optional feature only).

Ports:
- clk  in  1  single clock for all logic and both BRAM ports.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  write side: data valid.
- s_ready  out  1  write side: FIFO can accept.
- s_data  in  DATA_WIDTH  write data.
- m_valid  out  1  read side: m_data valid.
- m_ready  in  1  read side: consumer accepts.
- m_data  out  DATA_WIDTH  read data (FWFT).

Behaviour:
- Clocking/reset: one clock (clk); reset rst_n is synchronous, active-low.
- Transfers: push when s_valid && s_ready at a rising edge; pop when m_valid && m_ready.
- Storage: one SB_RAM40_4K, READ_MODE = WRITE_MODE = log2(16/DATA_WIDTH).
  - Data bits are mapped onto RAM lanes as for the existing wrappers: width 8 uses even bits, width 4 uses bit 4i+1, width 2 uses bit 8i+3.
  - MASK is tied 0; clock enables are tied 1; the address is zero-extended to 11 bits.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1). The RAM holds words when wr_ptr != rd_ptr.
- Output stage: 2-entry prefetch buffer fed by BRAM reads with 1-cycle read latency.
  - A read (RE=1, RADDR=rd_ptr[ADDR_WIDTH-1:0], rd_ptr++) issues in a cycle when RAM is non-empty and (buffered entries + reads in flight − pop this cycle) < 2.
  - Read data lands in the buffer at the next edge; m_data is the buffer head.
- Read-after-write: a read never targets a word written in the same cycle (comparison uses registered wr_ptr), so BRAM read-during-write data is never used.
- Latency: a word pushed at edge N is on m_data with m_valid=1 in the cycle after edge N+2 when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Occupancy count covers RAM + in-flight + buffer entries; it is 0..2^ADDR_WIDTH and is updated +1 on push, −1 on pop, unchanged on both.
- s_ready = (count < 2^ADDR_WIDTH), registered-count based. At full, a simultaneous pop does not allow a push that cycle.
- Empty: m_valid=0; m_ready is ignored. m_data holds its last value and has no meaning while m_valid=0.
- m_data stability: when m_valid && !m_ready, m_data and m_valid hold stable.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, buffer empty, m_valid=0, m_data=0.
  - s_ready=0 while rst_n=0, then 1 from the first cycle after release.
  - RAM contents are not cleared.
- Reset mid-operation: all stored and in-flight words are discarded. Read data returning at the reset edge is dropped, and no stale word appears after release.
- Illegal stimulus: s_valid while s_ready=0 is ignored (no write, no pointer change).

Optional Feature:
- Macro: BRAM_FIFO_LEVEL_EN.
- Defined: adds three outputs.
  - level out ADDR_WIDTH+1 = count.
  - almost_full out 1 = (count >= ALMOST_FULL_THRESH).
  - almost_empty out 1 = (count <= ALMOST_EMPTY_THRESH).
  - All three are registered and reflect count after the current edge's push/pop.
  - Reset values: level=0, almost_full=0, almost_empty=1.
- Not defined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Latency, default params: push 16'hA5A5 at edge 5, m_ready=1 -> m_valid=1 with m_data=16'hA5A5 in cycle after edge 7; m_valid=0 after pop.
- Fill, DATA_WIDTH=8/ADDR_WIDTH=9, m_ready=0: push 0..511 -> s_ready=0 after 512th push; extra push of 8'hFF ignored. Drain returns 0..511 in order, then m_valid=0.
- Streaming: continuous s_valid and m_ready for 3000 words at width 2 (pointer wrap) -> output order equals input order; no bubbles after the first word.
- Backpressure: random m_ready at 30% duty, width 4 -> m_data stable while stalled; no loss or duplication over 10000 words.
- Full with simultaneous pop: at count=256 (width 16), assert s_valid and m_ready -> pop accepted, push rejected; count=255 next cycle, s_ready=1.
- Reset mid-stream: rst_n=0 for 1 cycle with 100 words stored -> m_valid=0 and s_ready=1 after release; next push 16'h1234 is the first word out. With BRAM_FIFO_LEVEL_EN: level=0, almost_empty=1.
